// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented carry-chain adder/subtractor with valid/ready
// handshake. Operands are captured in an input rank, then STAGES = WIDTH/SEG
// adder stages each resolve one SEG-bit slice. The final stage registers
// directly drive the outputs, so an accepted operation emerges STAGES edges
// after the edge that accepted it.
// Optional feature: define PIPELINED_ADDER_SAT_EN to add the SATURATE input
// (signed saturation on overflow, no extra latency).
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SUBTRACT,
  input  logic [WIDTH-1:0] TERM_A,
  input  logic [WIDTH-1:0] TERM_B,
  input  logic             CI,
`ifdef PIPELINED_ADDER_SAT_EN
  input  logic             SATURATE,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ADDER_OUT,
  output logic             CO,
  output logic             HCO,
  output logic             OVO,
  output logic             ZERO
);

  localparam int STAGES = WIDTH / SEG;
  localparam int F      = STAGES - 1;

  if ((WIDTH % SEG) != 0 || SEG < 4 || WIDTH < 8) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of SEG, SEG >= 4, WIDTH >= 8");
  end

  // Signed clamp applied only when saturation is requested and the sum overflowed;
  // the sign of the overflow follows the common sign of the operands.
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] val,
                                                 input logic ovf, input logic en,
                                                 input logic neg);
    logic signed [WIDTH-1:0] lim;
    lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return (en && ovf) ? lim : val;
  endfunction

  logic sat_in;
`ifdef PIPELINED_ADDER_SAT_EN
  assign sat_in = SATURATE;
`else
  assign sat_in = 1'b0;
`endif

  // Whole pipeline advances together whenever the output slot can move.
  logic adv;
  assign adv       = ~OUT_VALID | OUT_READY;
  assign IN_READY  = adv;

  // Input rank (b and carry already conditioned for subtraction)
  logic             vld_p0;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic             c_p0, sub_p0, sat_p0;

  // Adder stage registers: word holds finished sum slices on top and the
  // still-pending operand A slices below, rotating one slice per stage.
  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  word_p [STAGES];
  logic [WIDTH-1:0]  b_p    [STAGES];
  logic              cy_p   [STAGES];
  logic              sub_p  [STAGES];
  logic              sat_p  [STAGES];
  logic              hco_p  [STAGES];

  logic [WIDTH-1:0]  word_i [STAGES];
  logic [WIDTH-1:0]  b_i    [STAGES];
  logic              c_i    [STAGES];
  logic              sub_i  [STAGES];
  logic              sat_i  [STAGES];
  logic              hco_i  [STAGES];
  logic [SEG:0]      sum_c  [STAGES];
  logic [WIDTH-1:0]  word_n [STAGES];
  logic [4:0]        half_c;
  logic              ovf_f;
  logic [WIDTH-1:0]  res_f;

  // Per-stage slice addition fed by the previous rank.
  always_comb begin
    half_c    = {1'b0, a_p0[3:0]} + {1'b0, b_p0[3:0]} + {4'b0000, c_p0};
    word_i[0] = a_p0;
    b_i[0]    = b_p0;
    c_i[0]    = c_p0;
    sub_i[0]  = sub_p0;
    sat_i[0]  = sat_p0;
    hco_i[0]  = half_c[4] ^ sub_p0;
    for (int s = 1; s < STAGES; s++) begin
      word_i[s] = word_p[s-1];
      b_i[s]    = b_p[s-1];
      c_i[s]    = cy_p[s-1];
      sub_i[s]  = sub_p[s-1];
      sat_i[s]  = sat_p[s-1];
      hco_i[s]  = hco_p[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      sum_c[s]  = {1'b0, word_i[s][SEG-1:0]} + {1'b0, b_i[s][SEG-1:0]}
                + {{SEG{1'b0}}, c_i[s]};
      word_n[s] = {sum_c[s][SEG-1:0], word_i[s][WIDTH-1:SEG]};
    end
  end

  // Final-stage overflow and optional clamp.
  always_comb begin
    ovf_f = word_i[F][SEG-1] ^ b_i[F][SEG-1] ^ sum_c[F][SEG-1] ^ sum_c[F][SEG];
    res_f = sat_clamp(word_n[F], ovf_f, sat_i[F], word_i[F][SEG-1]);
  end

  // Datapath ranks: load on advance, no reset needed.
  always_ff @(posedge CLK) begin
    if (adv) begin
      // input rank
      a_p0   <= TERM_A;
      b_p0   <= TERM_B ^ {WIDTH{SUBTRACT}};
      c_p0   <= CI ^ SUBTRACT;
      sub_p0 <= SUBTRACT;
      sat_p0 <= sat_in;
      // adder stages
      for (int s = 0; s < STAGES; s++) begin
        word_p[s] <= word_n[s];
        b_p[s]    <= b_i[s] >> SEG;
        cy_p[s]   <= sum_c[s][SEG];
        sub_p[s]  <= sub_i[s];
        sat_p[s]  <= sat_i[s];
        hco_p[s]  <= hco_i[s];
      end
    end
  end

  // Valid bits and output registers; reset discards everything in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_p0    <= 1'b0;
      vld_p     <= '0;
      ADDER_OUT <= '0;
      CO        <= 1'b0;
      HCO       <= 1'b0;
      OVO       <= 1'b0;
      ZERO      <= 1'b0;
    end else if (adv) begin
      vld_p0   <= IN_VALID;
      vld_p[0] <= vld_p0;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
      // output stage
      ADDER_OUT <= res_f;
      CO        <= sum_c[F][SEG] ^ sub_i[F];
      HCO       <= hco_i[F];
      OVO       <= ovf_f;
      ZERO      <= ~|res_f;
    end
  end

  assign OUT_VALID = vld_p[F];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, SEG=8).
module tb_pipelined_adder;

  logic        clk, rst_n, in_valid, in_ready, subtract, ci, saturate;
  logic        out_valid, out_ready, co, hco, ovo, zero;
  logic [31:0] term_a, term_b, adder_out;
  int          total, passed;

  pipelined_adder #(.WIDTH(32), .SEG(8)) dut (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SUBTRACT(subtract), .TERM_A(term_a), .TERM_B(term_b), .CI(ci),
`ifdef PIPELINED_ADDER_SAT_EN
    .SATURATE(saturate),
`endif
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .ADDER_OUT(adder_out),
    .CO(co), .HCO(hco), .OVO(ovo), .ZERO(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one operation into an empty pipeline and waits (bounded) for its result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic c, input logic st, output logic [31:0] r,
                       output logic co_o, output logic hco_o, output logic ovo_o,
                       output logic zero_o, output int lat);
    @(negedge clk);
    term_a = a; term_b = b; subtract = s; ci = c; saturate = st;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = adder_out; co_o = co; hco_o = hco; ovo_o = ovo; zero_o = zero;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (adder_out !== 32'h0) $display("FAIL reset_adder_out: got %h want 00000000", adder_out); else passed++;
    total++; if (co !== 1'b0) $display("FAIL reset_co: got %b want 0", co); else passed++;
    total++; if (hco !== 1'b0) $display("FAIL reset_hco: got %b want 0", hco); else passed++;
    total++; if (ovo !== 1'b0) $display("FAIL reset_ovo: got %b want 0", ovo); else passed++;
    total++; if (zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_add;
    logic [31:0] r; logic c_o, h_o, v_o, z_o; int lat;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (lat !== 4) $display("FAIL add_latency: got %0d want 4", lat); else passed++;
    total++; if (r !== 32'h0000_0100) $display("FAIL add_ff_1_result: got %h want 00000100", r); else passed++;
    total++; if (c_o !== 1'b0) $display("FAIL add_ff_1_co: got %b want 0", c_o); else passed++;
    total++; if (h_o !== 1'b1) $display("FAIL add_ff_1_hco: got %b want 1", h_o); else passed++;
    total++; if (v_o !== 1'b0) $display("FAIL add_ff_1_ovo: got %b want 0", v_o); else passed++;
    total++; if (z_o !== 1'b0) $display("FAIL add_ff_1_zero: got %b want 0", z_o); else passed++;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== 32'h0) $display("FAIL add_wrap_result: got %h want 00000000", r); else passed++;
    total++; if (c_o !== 1'b1) $display("FAIL add_wrap_co: got %b want 1", c_o); else passed++;
    total++; if (z_o !== 1'b1) $display("FAIL add_wrap_zero: got %b want 1", z_o); else passed++;
    total++; if (v_o !== 1'b0) $display("FAIL add_wrap_ovo: got %b want 0", v_o); else passed++;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== 32'h2345_678A) $display("FAIL add_ci_result: got %h want 2345678a", r); else passed++;
    total++; if (h_o !== 1'b0) $display("FAIL add_ci_hco: got %b want 0", h_o); else passed++;
    total++; if (c_o !== 1'b0) $display("FAIL add_ci_co: got %b want 0", c_o); else passed++;
  endtask

  task automatic test_subtract;
    logic [31:0] r; logic c_o, h_o, v_o, z_o; int lat;
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== 32'hFFFF_FFFE) $display("FAIL sub_5_7_result: got %h want fffffffe", r); else passed++;
    total++; if (c_o !== 1'b1) $display("FAIL sub_5_7_borrow: got %b want 1", c_o); else passed++;
    total++; if (h_o !== 1'b1) $display("FAIL sub_5_7_hborrow: got %b want 1", h_o); else passed++;
    total++; if (v_o !== 1'b0) $display("FAIL sub_5_7_ovo: got %b want 0", v_o); else passed++;
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== 32'h7FFF_FFFF) $display("FAIL sub_min_1_result: got %h want 7fffffff", r); else passed++;
    total++; if (v_o !== 1'b1) $display("FAIL sub_min_1_ovo: got %b want 1", v_o); else passed++;
    total++; if (c_o !== 1'b0) $display("FAIL sub_min_1_borrow: got %b want 0", c_o); else passed++;
    do_op(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (z_o !== 1'b1) $display("FAIL sub_equal_zero: got %b want 1", z_o); else passed++;
    total++; if (h_o !== 1'b0) $display("FAIL sub_equal_hborrow: got %b want 0", h_o); else passed++;
    do_op(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== 32'h0000_0006) $display("FAIL sub_borrow_in_result: got %h want 00000006", r); else passed++;
    total++; if (c_o !== 1'b0) $display("FAIL sub_borrow_in_co: got %b want 0", c_o); else passed++;
  endtask

  task automatic test_saturate;
    logic [31:0] r; logic c_o, h_o, v_o, z_o; int lat;
    logic [31:0] exp_pos, exp_neg;
`ifdef PIPELINED_ADDER_SAT_EN
    exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h8000_0000; exp_neg = 32'h7FFF_FFFF;
`endif
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== exp_pos) $display("FAIL sat_pos_result: got %h want %h", r, exp_pos); else passed++;
    total++; if (v_o !== 1'b1) $display("FAIL sat_pos_ovo: got %b want 1", v_o); else passed++;
    total++; if (lat !== 4) $display("FAIL sat_latency: got %0d want 4", lat); else passed++;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== exp_neg) $display("FAIL sat_neg_result: got %h want %h", r, exp_neg); else passed++;
    total++; if (c_o !== 1'b1) $display("FAIL sat_neg_co: got %b want 1", c_o); else passed++;
    total++; if (z_o !== 1'b0) $display("FAIL sat_neg_zero: got %b want 0", z_o); else passed++;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== 32'h8000_0000) $display("FAIL nosat_wrap_result: got %h want 80000000", r); else passed++;
    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1, r, c_o, h_o, v_o, z_o, lat);
    total++; if (r !== 32'h0000_0003) $display("FAIL sat_no_ovf_result: got %h want 00000003", r); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_r [8];
    int rcv, first;
    logic gap;
    exp_r[0] = 32'h1111_1210; exp_r[1] = 32'h2222_2321;
    exp_r[2] = 32'h3333_3432; exp_r[3] = 32'h4444_4543;
    exp_r[4] = 32'h5555_5654; exp_r[5] = 32'h6666_6765;
    exp_r[6] = 32'h7777_7876; exp_r[7] = 32'h8888_8987;
    rcv = 0; first = -1; gap = 1'b0;
    out_ready = 1'b1; subtract = 1'b0; ci = 1'b0; saturate = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = n;
        if (rcv < 8) begin
          total++;
          if (adder_out !== exp_r[rcv]) $display("FAIL b2b_result_%0d: got %h want %h", rcv, adder_out, exp_r[rcv]);
          else passed++;
        end
        rcv++;
      end else if (rcv > 0 && rcv < 8) gap = 1'b1;
      if (n < 8) begin
        term_a = 32'h1111_1111 * (n + 1); term_b = 32'h0000_00FF; in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    total++; if (first !== 5) $display("FAIL b2b_first_valid: got %0d want 5", first); else passed++;
    total++; if (rcv !== 8) $display("FAIL b2b_count: got %0d want 8", rcv); else passed++;
    total++; if (gap !== 1'b0) $display("FAIL b2b_contiguous: got gap=%b want 0", gap); else passed++;
  endtask

  task automatic test_stall;
    int sent, rcv;
    sent = 0; rcv = 0;
    subtract = 1'b0; ci = 1'b0; saturate = 1'b0; term_b = 32'h0000_0010;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      out_ready = (c >= 10);
      #1;
      if (c >= 5 && c < 10) begin
        total++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid_c%0d: got %b want 1", c, out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_c%0d: got %b want 0", c, in_ready); else passed++;
        total++; if (adder_out !== 32'h0000_0100) $display("FAIL stall_frozen_c%0d: got %h want 00000100", c, adder_out); else passed++;
      end
      if (c == 9) begin
        total++; if (sent !== 5) $display("FAIL stall_occupancy: got %0d want 5", sent); else passed++;
      end
      if (out_valid && out_ready) begin
        if (rcv < 10) begin
          total++;
          if (adder_out !== 32'h0000_0100 + rcv) $display("FAIL stall_order_%0d: got %h want %h", rcv, adder_out, 32'h0000_0100 + rcv);
          else passed++;
        end
        rcv++;
      end
      if (in_ready && sent < 10) begin
        term_a = 32'h0000_00F0 + sent; in_valid = 1'b1; sent++;
      end else in_valid = 1'b0;
    end
    total++; if (rcv !== 10) $display("FAIL stall_received: got %0d want 10", rcv); else passed++;
  endtask

  task automatic test_reset_inflight;
    int wait_n, seen;
    out_ready = 1'b0; subtract = 1'b0; ci = 1'b0; saturate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      term_a = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_0001 * i;
      term_b = (i == 0) ? 32'h0000_0001 : 32'h0000_0001 * i;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    total++; if (out_valid !== 1'b1) $display("FAIL inflight_pre_valid: got %b want 1", out_valid); else passed++;
    total++; if (co !== 1'b1 || zero !== 1'b1) $display("FAIL inflight_pre_flags: got co=%b zero=%b want co=1 zero=1", co, zero); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL inflight_reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (adder_out !== 32'h0) $display("FAIL inflight_reset_out: got %h want 00000000", adder_out); else passed++;
    total++; if ({co, hco, ovo, zero} !== 4'b0000) $display("FAIL inflight_reset_flags: got %b want 0000", {co, hco, ovo, zero}); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL inflight_reset_in_ready: got %b want 1", in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL inflight_ghosts: got %0d want 0", seen); else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; subtract = 1'b0; ci = 1'b0;
    saturate = 1'b0; term_a = '0; term_b = '0;
    test_reset;
    test_add;
    test_subtract;
    test_saturate;
    test_back_to_back;
    test_stall;
    test_reset_inflight;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SEG, default 8: carry-chain segment width per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 Port IN_VALID  input  1  operand set present.
REQ-006 Port IN_READY  output  1  block accepts operands this cycle.
REQ-007 Port SUBTRACT  input  1  1 = TERM_A - TERM_B, 0 = TERM_A + TERM_B.
REQ-008 Port TERM_A, TERM_B  input  WIDTH  operands.
REQ-009 Port CI  input  1  carry-in; borrow-in when SUBTRACT=1.
REQ-010 Port OUT_VALID  output  1  result present.
REQ-011 Port OUT_READY  input  1  consumer takes result this cycle.
REQ-012 Port ADDER_OUT  output  WIDTH  result; CO, HCO, OVO, ZERO  output  1 each  carry/borrow out, carry out of bit 3, signed overflow, result-is-zero.

Function
REQ-013 Parameter legality: WIDTH multiple of SEG, SEG >= 4, WIDTH >= 8; other values are illegal and produce an elaboration error.
REQ-014 Subtract: TERM_B inverted bitwise and CI inverted at stage 0; CO and HCO inverted at output, so both read as borrow when SUBTRACT=1.
REQ-015 Transfer in on rising edge with IN_VALID & IN_READY; transfer out on rising edge with OUT_VALID & OUT_READY.
REQ-016 Stage s (0..STAGES-1) adds bits [s*SEG+SEG-1 : s*SEG] plus carry from stage s-1 and registers sum slice and carry; upper operand bits are skewed through registers, lower result slices are delayed, so all slices of one operation leave together.
REQ-017 Latency exactly STAGES cycles: accepted at edge k with no stall -> OUT_VALID high and result on outputs after edge k+STAGES.
REQ-018 Throughput one operation per cycle with OUT_READY held 1; back-to-back operations never mix slices.
REQ-019 IN_READY = ~OUT_VALID | OUT_READY (combinational); when 0 every stage holds, no stage advances, no data lost or duplicated.
REQ-020 Each stage carries a valid bit; bubbles propagate; OUT_VALID = valid bit of last stage.
REQ-021 ADDER_OUT and flags stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 HCO = carry out of bit 3 (stage 0); OVO = carry into MSB XOR carry out of MSB; ZERO = NOR of final ADDER_OUT.
REQ-023 Arithmetic modulo 2^WIDTH; e.g. all-ones + 1 -> 0, CO=1, ZERO=1.
REQ-024 Simultaneous output take and input accept in same cycle is legal; full pipeline keeps full occupancy.

Reset
REQ-025 RESET_N low asynchronously clears all stage valid bits: OUT_VALID=0, ADDER_OUT=0, CO=HCO=OVO=0, ZERO=0.
REQ-026 IN_READY=1 during and after reset; in-flight operations discarded, none emerge after RESET_N rises.
REQ-027 First accept permitted on first rising edge with RESET_N high.

Configuration
REQ-028 Macro PIPELINED_ADDER_SAT_EN defined: extra input SATURATE (1 bit, sampled with operands); when 1 and OVO=1, ADDER_OUT clamps to 2^(WIDTH-1)-1 (positive overflow) or 2^(WIDTH-1) (negative overflow); OVO still reports overflow; ZERO evaluated on clamped value; CO, HCO unclamped.
REQ-029 Macro undefined: SATURATE port absent, wrap-around result always; no added latency either way.

Verification (WIDTH=32, SEG=8)
REQ-030 Add 0x0000_00FF + 0x0000_0001, CI=0 -> after 4 cycles ADDER_OUT=0x0000_0100, CO=0, HCO=1, OVO=0, ZERO=0.
REQ-031 Subtract 0x0000_0005 - 0x0000_0007, CI=0 -> 0xFFFF_FFFE, CO=1 (borrow), OVO=0; 0x8000_0000 - 1 -> 0x7FFF_FFFF, OVO=1.
REQ-032 8 back-to-back adds with OUT_READY=1 -> 8 consecutive OUT_VALID cycles, results in order, first after 4 cycles.
REQ-033 Pipeline full, OUT_READY=0 for 5 cycles -> IN_READY=0, ADDER_OUT frozen; release -> all results in order, none lost.
REQ-034 RESET_N low with 3 operations in flight -> OUT_VALID=0 immediately; none appear after release.
REQ-035 With PIPELINED_ADDER_SAT_EN, SATURATE=1: 0x7FFF_FFFF + 1 -> 0x7FFF_FFFF, OVO=1; without macro -> 0x8000_0000, OVO=1.
